// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states and read-return owner codes.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    E_FORCE = 2'd1,
    E_BURST = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_E    = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter; clr wins over inc, and clr with inc restarts the count at 1.
module dmem_arbiter_sat_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MAX   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        count <= '0;
    else if (clr)                     count <= inc ? WIDTH'(1) : '0;
    else if (inc && (count < MAX_V))  count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline M stage (priority)
// and the decryption engine, with starvation forcing and capped engine bursts.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              e_req,
  input  logic              e_wren,
  input  logic              e_lock,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned LW = $clog2(LOCK_MAX + 1);

  arb_state_e    state_q, state_d;
  rd_owner_e     rd_owner_q;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] lock_cnt;
  logic          p_win, e_win, use_arb;
  logic          starve_inc, starve_clr, lock_inc, lock_clr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  // Grant decode and next state; E_FORCE/E_BURST fall back to plain ARB rules when they cannot serve the engine.
  always_comb begin
    state_d    = state_q;
    p_win      = 1'b0;
    e_win      = 1'b0;
    use_arb    = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    lock_inc   = 1'b0;
    lock_clr   = 1'b0;

    unique case (state_q)
      ARB: use_arb = 1'b1;
      E_FORCE: begin
        starve_clr = 1'b1;
        if (e_req) begin
          e_win = 1'b1;
          if (e_lock) begin
            state_d  = E_BURST;
            lock_clr = 1'b1;
            lock_inc = 1'b1;
          end else begin
            state_d = ARB;
          end
        end else begin
          use_arb = 1'b1;
        end
      end
      E_BURST: begin
        if (e_req && e_lock && (lock_cnt < LW'(LOCK_MAX))) begin
          e_win    = 1'b1;
          lock_inc = 1'b1;
        end else begin
          use_arb  = 1'b1;
          lock_clr = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase

    if (use_arb) begin
      state_d = ARB;
      if (p_req) begin
        p_win = 1'b1;
        if (e_req) begin
          starve_inc = 1'b1;
          if (starve_cnt >= SW'(STARVE_MAX - 1)) state_d = E_FORCE;
        end
      end else if (e_req) begin
        e_win      = 1'b1;
        starve_clr = 1'b1;
        if (e_lock) begin
          state_d  = E_BURST;
          lock_clr = 1'b1;
          lock_inc = 1'b1;
        end
      end
    end

    // Nothing is granted while reset is held, so every output reads zero.
    if (reset) begin
      p_win = 1'b0;
      e_win = 1'b0;
    end
  end

  dmem_arbiter_sat_counter #(.WIDTH(SW), .MAX(STARVE_MAX)) u_starve_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .count (starve_cnt)
  );

  dmem_arbiter_sat_counter #(.WIDTH(LW), .MAX(LOCK_MAX)) u_lock_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (lock_inc),
    .clr   (lock_clr),
    .count (lock_cnt)
  );

  // Remember who issued the read so next cycle's q_dmem goes to the right requester.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 rd_owner_q <= OWN_NONE;
    else if (p_win && !p_wren) rd_owner_q <= OWN_P;
    else if (e_win && !e_wren) rd_owner_q <= OWN_E;
    else                       rd_owner_q <= OWN_NONE;
  end

  assign p_stall      = p_req && !p_win && !reset;
  assign e_gnt        = e_win;
  assign address_dmem = p_win ? p_addr  : (e_win ? e_addr  : '0);
  assign data         = p_win ? p_wdata : (e_win ? e_wdata : '0);
  assign wren         = p_win ? p_wren  : (e_win && e_wren);

  assign p_rvalid = (rd_owner_q == OWN_P);
  assign e_rvalid = (rd_owner_q == OWN_E);
  assign p_rdata  = p_rvalid ? q_dmem : '0;
  assign e_rdata  = e_rvalid ? q_dmem : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_dmem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int LOCK_MAX   = 16;

  logic        clock, reset;
  logic        p_req, p_wren, p_stall, p_rvalid;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic        e_req, e_wren, e_lock, e_gnt, e_rvalid;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [31:0] address_dmem, data, q_dmem;
  logic        wren;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory environment
  logic [31:0] mem [256];
  logic        mem_fill = 1'b0;
  logic        q_ovr_en = 1'b0;
  logic [31:0] q_ovr    = '0;

  // Reference model state
  int          m_starve, m_burst, m_owner, m_who;
  bit          m_owed;
  logic [31:0] m_rdata;
  logic [31:0] shadow [256];

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .e_req(e_req), .e_wren(e_wren), .e_lock(e_lock), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] fill_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clock) begin
    if (mem_fill) for (int i = 0; i < 256; i++) mem[i] <= fill_word(i);
    else if (wren) mem[address_dmem[7:0]] <= data;
    q_dmem <= q_ovr_en ? q_ovr : mem[address_dmem[7:0]];
  end

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    p_req = 0; p_wren = 0; p_addr = '0; p_wdata = '0;
    e_req = 0; e_wren = 0; e_lock = 0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    p_req = 1; p_wren = 1; p_addr = 32'h44; p_wdata = 32'h1111;
    e_req = 1; e_wren = 1; e_lock = 1; e_addr = 32'h55; e_wdata = 32'h2222;
    next_cycle();
    #2;
    n_tests++;
    if ({p_stall, e_gnt, wren, p_rvalid, e_rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {p_stall, e_gnt, wren, p_rvalid, e_rvalid});
    end
    n_tests++;
    if ({address_dmem, data, p_rdata, e_rdata} !== 128'b0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h data=%h prd=%h erd=%h want all 0", address_dmem, data, p_rdata, e_rdata);
    end
    idle_inputs();
    @(negedge clock);
    reset = 0;
    next_cycle();
  endtask

  task automatic test_proc_load();
    q_ovr_en = 1; q_ovr = 32'hDEAD_BEEF;
    p_req = 1; p_wren = 0; p_addr = 32'h10;
    #2;
    n_tests++;
    if (p_stall !== 1'b0) begin n_fail++; $display("FAIL load_stall: got %b want 0", p_stall); end
    n_tests++;
    if ({address_dmem, wren} !== {32'h10, 1'b0}) begin
      n_fail++; $display("FAIL load_port: got addr=%h wren=%b want 10/0", address_dmem, wren);
    end
    next_cycle();
    p_req = 0;
    #2;
    n_tests++;
    if ({p_rvalid, p_rdata, e_rvalid} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      n_fail++; $display("FAIL load_return: got rv=%b rd=%h erv=%b want 1/deadbeef/0", p_rvalid, p_rdata, e_rvalid);
    end
    q_ovr_en = 0;
    next_cycle();
  endtask

  task automatic test_starvation();
    p_req = 1; p_wren = 0; p_addr = 32'hA0;
    e_req = 1; e_wren = 0; e_lock = 0; e_addr = 32'hB0;
    for (int c = 0; c < 6; c++) begin
      bit exp_p;
      exp_p = (c != 4);
      #2;
      n_tests++;
      if ({p_stall, e_gnt} !== {!exp_p, !exp_p}) begin
        n_fail++; $display("FAIL starve_c%0d: got stall=%b gnt=%b want %b/%b", c, p_stall, e_gnt, !exp_p, !exp_p);
      end
      n_tests++;
      if (address_dmem !== (exp_p ? 32'hA0 : 32'hB0)) begin
        n_fail++; $display("FAIL starve_addr_c%0d: got %h want %h", c, address_dmem, exp_p ? 32'hA0 : 32'hB0);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_burst_cap();
    e_req = 1; e_lock = 1; e_wren = 0; e_addr = 32'hC0;
    for (int c = 0; c < 20; c++) begin
      #2;
      n_tests++;
      if ({e_gnt, p_stall} !== 2'b10) begin
        n_fail++; $display("FAIL lockalone_c%0d: got gnt=%b stall=%b want 1/0", c, e_gnt, p_stall);
      end
      next_cycle();
    end
    e_req = 0; e_lock = 0;
    next_cycle();
    e_req = 1; e_lock = 1;
    p_wren = 0; p_addr = 32'hD0;
    for (int c = 0; c < 18; c++) begin
      bit exp_e, exp_s;
      if (c == 3) p_req = 1;
      if (c == 17) p_req = 0;
      exp_e = (c != 16);
      exp_s = (c >= 3) && (c <= 15);
      #2;
      n_tests++;
      if ({e_gnt, p_stall} !== {exp_e, exp_s}) begin
        n_fail++; $display("FAIL burstcap_c%0d: got gnt=%b stall=%b want %b/%b", c, e_gnt, p_stall, exp_e, exp_s);
      end
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_burst_preempt();
    e_req = 1; e_lock = 1; e_wren = 0; e_addr = 32'hE0;
    p_wren = 0; p_addr = 32'hF0;
    for (int c = 0; c < 7; c++) begin
      bit exp_e, exp_s;
      if (c == 2) p_req = 1;
      if (c == 5) e_lock = 0;
      if (c == 6) p_req = 0;
      exp_e = (c != 5);
      exp_s = (c >= 2) && (c <= 4);
      #2;
      n_tests++;
      if ({e_gnt, p_stall} !== {exp_e, exp_s}) begin
        n_fail++; $display("FAIL preempt_c%0d: got gnt=%b stall=%b want %b/%b", c, e_gnt, p_stall, exp_e, exp_s);
      end
      if (c == 5) begin
        n_tests++;
        if (address_dmem !== 32'hF0) begin n_fail++; $display("FAIL preempt_addr: got %h want f0", address_dmem); end
      end
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_write_then_read();
    e_req = 1; e_wren = 1; e_lock = 0; e_addr = 32'h20; e_wdata = 32'h1234;
    #2;
    n_tests++;
    if ({e_gnt, wren, address_dmem, data} !== {1'b1, 1'b1, 32'h20, 32'h1234}) begin
      n_fail++; $display("FAIL wr_port: got gnt=%b wren=%b addr=%h data=%h want 1/1/20/1234", e_gnt, wren, address_dmem, data);
    end
    next_cycle();
    idle_inputs();
    p_req = 1; p_wren = 0; p_addr = 32'h20;
    #2;
    n_tests++;
    if ({wren, p_stall, e_rvalid} !== 3'b000) begin
      n_fail++; $display("FAIL rd_port: got wren=%b stall=%b erv=%b want 000", wren, p_stall, e_rvalid);
    end
    next_cycle();
    p_req = 0;
    #2;
    n_tests++;
    if ({p_rvalid, p_rdata} !== {1'b1, 32'h1234}) begin
      n_fail++; $display("FAIL rd_return: got rv=%b rd=%h want 1/1234", p_rvalid, p_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_midburst();
    e_req = 1; e_lock = 1; e_wren = 0; e_addr = 32'h30;
    #2;
    n_tests++;
    if (e_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt: got %b want 1", e_gnt); end
    next_cycle();
    #2;
    n_tests++;
    if ({e_gnt, e_rvalid} !== 2'b11) begin n_fail++; $display("FAIL midrst_inflight: got gnt=%b rv=%b want 11", e_gnt, e_rvalid); end
    #1 reset = 1;
    #1;
    n_tests++;
    if ({e_gnt, e_rvalid, p_rvalid, p_stall, wren, address_dmem, e_rdata} !== 69'b0) begin
      n_fail++; $display("FAIL midrst_async: got gnt=%b erv=%b prv=%b stall=%b wren=%b addr=%h erd=%h want all 0",
                         e_gnt, e_rvalid, p_rvalid, p_stall, wren, address_dmem, e_rdata);
    end
    idle_inputs();
    next_cycle();
    reset = 0;
    #2;
    n_tests++;
    if ({e_rvalid, p_rvalid, e_rdata} !== 34'b0) begin
      n_fail++; $display("FAIL midrst_after: got erv=%b prv=%b erd=%h want 0", e_rvalid, p_rvalid, e_rdata);
    end
    next_cycle();
  endtask

  function automatic int model_pick();
    if (m_burst > 0 && e_req && e_lock && m_burst < LOCK_MAX) return 2;
    if (m_owed && e_req) return 2;
    if (p_req) return 1;
    if (e_req) return 2;
    return 0;
  endfunction

  task automatic model_commit();
    if (m_burst > 0 && e_req && e_lock && m_burst < LOCK_MAX) begin
      m_burst++;
    end else begin
      if (m_owed) begin m_owed = 0; m_starve = 0; end
      m_burst = 0;
      if (m_who == 2) begin
        m_starve = 0;
        if (e_lock) m_burst = 1;
      end else if (m_who == 1 && e_req) begin
        if (m_starve < STARVE_MAX) m_starve++;
        if (m_starve == STARVE_MAX) m_owed = 1;
      end
    end
    m_owner = 0;
    if (m_who == 1) begin
      if (p_wren) shadow[p_addr[7:0]] = p_wdata;
      else begin m_owner = 1; m_rdata = shadow[p_addr[7:0]]; end
    end else if (m_who == 2) begin
      if (e_wren) shadow[e_addr[7:0]] = e_wdata;
      else begin m_owner = 2; m_rdata = shadow[e_addr[7:0]]; end
    end
  endtask

  task automatic test_random();
    int p_rate, e_rate;
    bit lock_mode, p_gnt_prev, e_gnt_prev;
    logic [31:0] exp_addr, exp_data;
    logic        exp_wren;
    reset = 1; idle_inputs();
    mem_fill = 1;
    next_cycle();
    mem_fill = 0;
    reset = 0;
    for (int i = 0; i < 256; i++) shadow[i] = fill_word(i);
    m_starve = 0; m_burst = 0; m_owed = 0; m_owner = 0; m_rdata = '0;
    p_gnt_prev = 0; e_gnt_prev = 0;
    p_rate = 50; e_rate = 50; lock_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        p_rate = $urandom_range(95, 20); e_rate = $urandom_range(95, 20); lock_mode = 1'($urandom_range(1));
      end
      if (!p_req || p_gnt_prev) begin
        p_req = ($urandom_range(99) < p_rate); p_wren = 1'($urandom_range(1));
        p_addr = 32'($urandom_range(63)); p_wdata = $urandom;
      end
      if (!e_req || e_gnt_prev) begin
        e_req = ($urandom_range(99) < e_rate); e_wren = 1'($urandom_range(1));
        e_addr = 32'($urandom_range(63)); e_wdata = $urandom;
        e_lock = lock_mode ? ($urandom_range(9) != 0) : ($urandom_range(9) == 0);
      end
      m_who = model_pick();
      exp_addr = (m_who == 1) ? p_addr  : (m_who == 2) ? e_addr  : 32'h0;
      exp_data = (m_who == 1) ? p_wdata : (m_who == 2) ? e_wdata : 32'h0;
      exp_wren = (m_who == 1) ? p_wren  : (m_who == 2) ? e_wren  : 1'b0;
      #2;
      n_tests++;
      if ({p_stall, e_gnt} !== {p_req && m_who != 1, m_who == 2}) begin
        n_fail++; $display("FAIL rnd_grant c%0d: got stall=%b gnt=%b want %b/%b", c, p_stall, e_gnt, p_req && m_who != 1, m_who == 2);
      end
      n_tests++;
      if ({address_dmem, data, wren} !== {exp_addr, exp_data, exp_wren}) begin
        n_fail++; $display("FAIL rnd_port c%0d: got %h/%h/%b want %h/%h/%b", c, address_dmem, data, wren, exp_addr, exp_data, exp_wren);
      end
      n_tests++;
      if ({p_rvalid, p_rdata} !== {m_owner == 1, (m_owner == 1) ? m_rdata : 32'h0}) begin
        n_fail++; $display("FAIL rnd_prd c%0d: got %b/%h want %b/%h", c, p_rvalid, p_rdata, m_owner == 1, (m_owner == 1) ? m_rdata : 32'h0);
      end
      n_tests++;
      if ({e_rvalid, e_rdata} !== {m_owner == 2, (m_owner == 2) ? m_rdata : 32'h0}) begin
        n_fail++; $display("FAIL rnd_erd c%0d: got %b/%h want %b/%h", c, e_rvalid, e_rdata, m_owner == 2, (m_owner == 2) ? m_rdata : 32'h0);
      end
      p_gnt_prev = (m_who == 1);
      e_gnt_prev = (m_who == 2);
      @(posedge clock);
      model_commit();
      @(negedge clock);
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_proc_load();
    test_starvation();
    test_burst_cap();
    test_burst_preempt();
    test_write_then_read();
    test_reset_midburst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
